// File: rtl/winner_policy_param.sv
// ---------------------------------------------------------------------------
// winner_policy_param
//
// Epsilon-greedy next-hop selector for a Q-routing node controller.
//
// A request on start (accepted only in IDLE) latches the routing inputs. The
// block then takes one of two paths:
//   explore : read the better-neighbour count from node memory, reduce the
//             random index modulo that count (one subtraction per cycle), then
//             read the neighbour ID at that table slot. Epsilon is decayed,
//             saturating at zero.
//   greedy  : compare the best neighbour Q against our own Q with a clear-win
//             ratio and, failing that, a hysteresis margin. Epsilon is passed
//             through unchanged.
// An empty neighbour table makes the explore path fall back to greedy.
//
// Ports
//   clock           in   rising-edge clock
//   nreset          in   asynchronous active-low reset
//   start           in   request, sampled in IDLE only
//   mode            in   0 greedy, 1/3 epsilon-greedy, 2 always explore
//   mybest          in   own best Q (12.4 fixed point)
//   bestvalue       in   best neighbour Q (12.4 fixed point)
//   besthop         in   hop ID belonging to bestvalue
//   bestneighbor_id in   ID of the best neighbour
//   my_node_id      in   this node's ID
//   epsilon         in   current exploration threshold
//   epsilon_step    in   decay applied per exploration
//   rand_in         in   free-running random word
//   mem_addr        out  node-memory read address
//   mem_rd_en       out  read strobe, data returned on mem_data next cycle
//   mem_data        in   node-memory read data
//   nexthop         out  selected hop (NO_HOP when none)
//   epsilon_next    out  epsilon after this decision
//   explored        out  last decision came from the explore path
//   busy            out  high whenever not IDLE
//   done            out  single-cycle completion pulse
// ---------------------------------------------------------------------------
module winner_policy_param #(
  parameter int WORD_WIDTH    = 16,
  parameter int IDX_WIDTH     = 4,
  parameter int MAX_NEIGHBORS = 16,
  parameter int BNC_ADDR      = 'h68C,
  parameter int BN_BASE_ADDR  = 'h668,
  parameter int ADDR_STRIDE   = 2,
  parameter int LO_COEF       = 1023,
  parameter int LO_FRAC       = 10,
  parameter int HI_COEF       = 33,
  parameter int HI_FRAC       = 15,
  parameter int NO_HOP        = 100
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [WORD_WIDTH-1:0] mybest,
  input  logic [WORD_WIDTH-1:0] bestvalue,
  input  logic [WORD_WIDTH-1:0] besthop,
  input  logic [WORD_WIDTH-1:0] bestneighbor_id,
  input  logic [WORD_WIDTH-1:0] my_node_id,
  input  logic [WORD_WIDTH-1:0] epsilon,
  input  logic [WORD_WIDTH-1:0] epsilon_step,
  input  logic [WORD_WIDTH-1:0] rand_in,
  output logic [WORD_WIDTH-1:0] mem_addr,
  output logic                  mem_rd_en,
  input  logic [WORD_WIDTH-1:0] mem_data,
  output logic [WORD_WIDTH-1:0] nexthop,
  output logic [WORD_WIDTH-1:0] epsilon_next,
  output logic                  explored,
  output logic                  busy,
  output logic                  done
);

  // Constants narrowed to the data-path width once, here.
  localparam logic [WORD_WIDTH-1:0] BNC_W     = WORD_WIDTH'(BNC_ADDR);
  localparam logic [WORD_WIDTH-1:0] BN_BASE_W = WORD_WIDTH'(BN_BASE_ADDR);
  localparam logic [WORD_WIDTH-1:0] STRIDE_W  = WORD_WIDTH'(ADDR_STRIDE);
  localparam logic [WORD_WIDTH-1:0] MAXN_W    = WORD_WIDTH'(MAX_NEIGHBORS);
  localparam logic [WORD_WIDTH-1:0] NO_HOP_W  = WORD_WIDTH'(NO_HOP);

  // Comparison widths: the clear-win test works on WORD+LO_FRAC bits, the
  // hysteresis test needs one extra bit for the sum of two products.
  localparam int LW = WORD_WIDTH + LO_FRAC;
  localparam int HW = WORD_WIDTH + HI_FRAC + 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_DECIDE,
    S_WAIT_CNT,
    S_CAP_CNT,
    S_MOD,
    S_WAIT_NB,
    S_CAP_NB,
    S_GREEDY1,
    S_GREEDY2,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  // Request inputs captured on acceptance.
  logic [IDX_WIDTH-1:0]  rand_q;
  logic [WORD_WIDTH-1:0] eps_q;
  logic [WORD_WIDTH-1:0] step_q;
  logic [WORD_WIDTH-1:0] mybest_q;
  logic [WORD_WIDTH-1:0] bestval_q;
  logic [WORD_WIDTH-1:0] besthop_q;
  logic [WORD_WIDTH-1:0] bnid_q;
  logic [WORD_WIDTH-1:0] myid_q;

  // Explore-path working registers.
  logic [WORD_WIDTH-1:0] cnt_q, cnt_d;
  logic [WORD_WIDTH-1:0] idx_q, idx_d;

  // Registered outputs.
  logic [WORD_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  mem_rd_en_q, mem_rd_en_d;
  logic [WORD_WIDTH-1:0] nexthop_q, nexthop_d;
  logic [WORD_WIDTH-1:0] eps_next_q, eps_next_d;
  logic                  explored_q, explored_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  load_w;
  logic [WORD_WIDTH-1:0] rand_slice_w;
  logic                  explore_w;
  logic [WORD_WIDTH-1:0] cnt_clamp_w;
  logic [LW-1:0]         lo_lhs_w, lo_rhs_w;
  logic [HW-1:0]         hi_lhs_w, hi_rhs_w;
  logic                  clear_win_w;
  logic                  hyst_win_w;
  logic [WORD_WIDTH-1:0] eps_decay_w;

  // Only the low IDX_WIDTH bits of the RNG word ever select anything.
  logic                  unused_rand_w;
  assign unused_rand_w = ^rand_in[WORD_WIDTH-1:IDX_WIDTH];

  assign load_w       = (state_q == S_IDLE) && start;
  assign rand_slice_w = WORD_WIDTH'(rand_q);

  // Mode 3 behaves exactly like mode 1.
  assign explore_w = (mode == 2'd2) || ((mode != 2'd0) && (rand_slice_w < eps_q));

  assign cnt_clamp_w = (mem_data > MAXN_W) ? MAXN_W : mem_data;

  // Clear win: bestvalue < LO_COEF/2^LO_FRAC * mybest, kept in integers.
  assign lo_lhs_w    = LW'(bestval_q) << LO_FRAC;
  assign lo_rhs_w    = LW'(mybest_q) * LW'(LO_COEF);
  assign clear_win_w = lo_lhs_w < lo_rhs_w;

  // Hysteresis: bestvalue < (1 + HI_COEF/2^HI_FRAC) * mybest, and never
  // route back through ourselves.
  assign hi_lhs_w   = HW'(bestval_q) << HI_FRAC;
  assign hi_rhs_w   = (HW'(mybest_q) << HI_FRAC) + HW'(mybest_q) * HW'(HI_COEF);
  assign hyst_win_w = (hi_lhs_w < hi_rhs_w) && (bnid_q != myid_q);

  assign eps_decay_w = (eps_q < step_q) ? '0 : (eps_q - step_q);

  // -------------------------------------------------------------------------
  // State register and all other flops
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q     <= S_IDLE;
      rand_q      <= '0;
      eps_q       <= '0;
      step_q      <= '0;
      mybest_q    <= '0;
      bestval_q   <= '0;
      besthop_q   <= '0;
      bnid_q      <= '0;
      myid_q      <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      mem_addr_q  <= '0;
      mem_rd_en_q <= 1'b0;
      nexthop_q   <= NO_HOP_W;
      eps_next_q  <= '0;
      explored_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_en_q <= mem_rd_en_d;
      nexthop_q   <= nexthop_d;
      eps_next_q  <= eps_next_d;
      explored_q  <= explored_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      if (load_w) begin
        rand_q    <= rand_in[IDX_WIDTH-1:0];
        eps_q     <= epsilon;
        step_q    <= epsilon_step;
        mybest_q  <= mybest;
        bestval_q <= bestvalue;
        besthop_q <= besthop;
        bnid_q    <= bestneighbor_id;
        myid_q    <= my_node_id;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     if (start) state_d = S_DECIDE;
      S_DECIDE:   state_d = explore_w ? S_WAIT_CNT : S_GREEDY1;
      S_WAIT_CNT: state_d = S_CAP_CNT;
      // An empty table leaves nothing to explore; fall back to greedy.
      S_CAP_CNT:  state_d = (cnt_clamp_w == '0) ? S_GREEDY1 : S_MOD;
      S_MOD:      if (idx_q < cnt_q) state_d = S_WAIT_NB;
      S_WAIT_NB:  state_d = S_CAP_NB;
      S_CAP_NB:   state_d = S_DONE;
      S_GREEDY1:  state_d = clear_win_w ? S_DONE : S_GREEDY2;
      S_GREEDY2:  state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output / data-path next values
  // -------------------------------------------------------------------------
  always_comb begin
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    mem_addr_d  = mem_addr_q;
    mem_rd_en_d = 1'b0;
    nexthop_d   = nexthop_q;
    eps_next_d  = eps_next_q;
    explored_d  = explored_q;
    // Both status flags follow the state being entered, so they line up
    // with it on the same edge.
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);

    unique case (state_q)
      S_DECIDE: begin
        if (explore_w) begin
          mem_addr_d  = BNC_W;
          mem_rd_en_d = 1'b1;
        end
      end
      S_CAP_CNT: begin
        cnt_d = cnt_clamp_w;
        idx_d = rand_slice_w;
      end
      S_MOD: begin
        // Modulo by repeated subtraction; the slice is small so the loop
        // is short and needs no divider.
        if (idx_q >= cnt_q) begin
          idx_d = idx_q - cnt_q;
        end else begin
          mem_addr_d  = BN_BASE_W + idx_q * STRIDE_W;
          mem_rd_en_d = 1'b1;
        end
      end
      S_CAP_NB: begin
        nexthop_d  = mem_data;
        explored_d = 1'b1;
        eps_next_d = eps_decay_w;
      end
      S_GREEDY1: begin
        if (clear_win_w) begin
          nexthop_d  = besthop_q;
          explored_d = 1'b0;
          eps_next_d = eps_q;
        end
      end
      S_GREEDY2: begin
        nexthop_d  = hyst_win_w ? besthop_q : NO_HOP_W;
        explored_d = 1'b0;
        eps_next_d = eps_q;
      end
      default: begin
      end
    endcase
  end

  assign mem_addr     = mem_addr_q;
  assign mem_rd_en    = mem_rd_en_q;
  assign nexthop      = nexthop_q;
  assign epsilon_next = eps_next_q;
  assign explored     = explored_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_winner_policy_param.sv
module tb_winner_policy_param;

  logic        clock = 1'b0;
  logic        nreset;
  logic        start;
  logic [1:0]  mode;
  logic [15:0] mybest, bestvalue, besthop, bestneighbor_id, my_node_id;
  logic [15:0] epsilon, epsilon_step, rand_in;
  logic [15:0] mem_addr;
  logic        mem_rd_en;
  logic [15:0] mem_data;
  logic [15:0] nexthop, epsilon_next;
  logic        explored, busy, done;

  always #5 clock = ~clock;

  winner_policy_param dut (
    .clock(clock), .nreset(nreset), .start(start), .mode(mode),
    .mybest(mybest), .bestvalue(bestvalue), .besthop(besthop),
    .bestneighbor_id(bestneighbor_id), .my_node_id(my_node_id),
    .epsilon(epsilon), .epsilon_step(epsilon_step), .rand_in(rand_in),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_data(mem_data),
    .nexthop(nexthop), .epsilon_next(epsilon_next), .explored(explored),
    .busy(busy), .done(done)
  );

  // Node memory: one-cycle read latency, every read address logged.
  logic [15:0] mem [0:4095];
  logic [15:0] addr_log [$];
  always @(posedge clock) begin
    if (mem_rd_en) begin
      addr_log.push_back(mem_addr);
      mem_data <= mem[mem_addr[11:0]];
    end
  end

  int checks = 0;
  int passes = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  typedef struct {
    int          mode;
    logic [15:0] mybest, bestvalue, besthop, bnid, myid, eps, step, rnd;
  } txn_t;

  typedef struct {
    logic [15:0] nh;
    logic [15:0] epsn;
    logic        expl;
    int          lat;
    int          nreads;
    logic [15:0] addr2;
  } exp_t;

  // Reference model: decision, result and latency straight from the rules.
  function automatic exp_t model(input txn_t t);
    exp_t   e;
    int     slice, cnt, idx, extra;
    bit     explore;
    longint mb, bv;
    slice   = int'(t.rnd) % 16;
    explore = (t.mode == 2) || (t.mode != 0 && slice < int'(t.eps));
    extra   = 0;
    e.nreads = 0;
    e.addr2  = 16'h0;
    if (explore) begin
      e.nreads = 1;
      cnt = int'(mem[12'h68C]);
      if (cnt > 16) cnt = 16;
      if (cnt != 0) begin
        idx      = slice % cnt;
        e.addr2  = 16'(16'h668 + 2 * idx);
        e.nh     = mem[e.addr2[11:0]];
        e.epsn   = (t.eps < t.step) ? 16'h0 : 16'(t.eps - t.step);
        e.expl   = 1'b1;
        e.lat    = 6 + slice / cnt;
        e.nreads = 2;
        return e;
      end
      extra = 2;
    end
    mb = longint'(t.mybest);
    bv = longint'(t.bestvalue);
    if (bv * 1024 < mb * 1023) begin
      e.nh  = t.besthop;
      e.lat = 2 + extra;
    end else begin
      e.nh  = (bv * 32768 < mb * (32768 + 33) && t.bnid != t.myid) ? t.besthop : 16'd100;
      e.lat = 3 + extra;
    end
    e.epsn = t.eps;
    e.expl = 1'b0;
    return e;
  endfunction

  task automatic drive(input txn_t t);
    mode            = 2'(t.mode);
    mybest          = t.mybest;
    bestvalue       = t.bestvalue;
    besthop         = t.besthop;
    bestneighbor_id = t.bnid;
    my_node_id      = t.myid;
    epsilon         = t.eps;
    epsilon_step    = t.step;
    rand_in         = t.rnd;
  endtask

  // Runs one request. With poke set, start is held high for the whole
  // operation including the DONE cycle; none of it may be accepted.
  task automatic run(input string name, input txn_t t, input bit poke);
    exp_t e;
    int   lat;
    bit   got;
    e = model(t);
    addr_log.delete();
    drive(t);
    start = 1'b1;
    @(posedge clock); #1;
    start = poke;
    check({name, "_busy_on_accept"}, 32'(busy), 32'd1);
    // Inputs other than mode must already be latched.
    mybest = 16'($urandom); bestvalue = 16'($urandom); besthop = 16'($urandom);
    bestneighbor_id = 16'($urandom); my_node_id = 16'($urandom);
    epsilon = 16'($urandom); epsilon_step = 16'($urandom); rand_in = 16'($urandom);
    got = 1'b0;
    lat = 0;
    for (int i = 1; i <= 60 && !got; i++) begin
      @(posedge clock); #1;
      if (done) begin
        got = 1'b1;
        lat = i;
      end
    end
    check({name, "_done_seen"}, 32'(got), 32'd1);
    check({name, "_latency"}, 32'(lat), 32'(e.lat));
    check({name, "_nexthop"}, 32'(nexthop), 32'(e.nh));
    check({name, "_epsilon_next"}, 32'(epsilon_next), 32'(e.epsn));
    check({name, "_explored"}, 32'(explored), 32'(e.expl));
    check({name, "_reads"}, 32'(addr_log.size()), 32'(e.nreads));
    if (e.nreads >= 1 && addr_log.size() >= 1)
      check({name, "_addr_cnt"}, 32'(addr_log[0]), 32'h68C);
    if (e.nreads == 2 && addr_log.size() >= 2)
      check({name, "_addr_nb"}, 32'(addr_log[1]), 32'(e.addr2));
    @(posedge clock); #1;
    start = 1'b0;
    check({name, "_done_one_cycle"}, 32'(done), 32'd0);
    check({name, "_idle_after"}, 32'(busy), 32'd0);
    @(posedge clock); #1;
    check({name, "_no_restart"}, 32'(busy), 32'd0);
    $display("txn %s mode=%0d rnd=%h nexthop=%0d eps_next=%0d explored=%0d lat=%0d",
             name, t.mode, t.rnd, nexthop, epsilon_next, explored, lat);
  endtask

  function automatic txn_t mk(input int md, input logic [15:0] mb, bv, bh, bn, my, ep, st, rn);
    txn_t t;
    t.mode = md; t.mybest = mb; t.bestvalue = bv; t.besthop = bh;
    t.bnid = bn; t.myid = my; t.eps = ep; t.step = st; t.rnd = rn;
    return t;
  endfunction

  initial begin
    txn_t t;
    int   k;
    for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
    mem_data = 16'h0;
    start = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    nreset = 1'b1;
    #1 nreset = 1'b0;
    #2;
    check("rst_nexthop", 32'(nexthop), 32'd100);
    check("rst_epsilon_next", 32'(epsilon_next), 32'd0);
    check("rst_explored", 32'(explored), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    @(negedge clock); @(negedge clock);
    nreset = 1'b1;
    @(negedge clock);

    // Directed cases.
    run("clear_win", mk(0, 16'h0100, 16'h00F0, 7, 1, 2, 9, 2, 16'h0003), 1'b0);
    run("hyst_self", mk(0, 16'h0100, 16'h0100, 7, 3, 3, 9, 2, 16'h0003), 1'b0);
    run("hyst_other", mk(0, 16'h0100, 16'h0100, 7, 5, 3, 9, 2, 16'h0003), 1'b0);
    mem[12'h68C] = 16'd5;
    mem[12'h66E] = 16'd42;
    run("explore_mod", mk(2, 16'h0100, 16'h0100, 7, 5, 3, 9, 2, 16'hA12D), 1'b0);
    run("eps_sat", mk(2, 16'h0100, 16'h0100, 7, 5, 3, 3, 5, 16'h000D), 1'b0);
    mem[12'h68C] = 16'd0;
    run("cnt_zero_win", mk(2, 16'h0100, 16'h00F0, 9, 5, 3, 9, 2, 16'h000D), 1'b0);
    run("cnt_zero_hyst", mk(2, 16'h0100, 16'h0100, 9, 5, 3, 9, 2, 16'h000D), 1'b0);
    mem[12'h68C] = 16'd40;
    run("cnt_clamp", mk(2, 16'h0100, 16'h0100, 9, 5, 3, 9, 2, 16'h000B), 1'b0);
    mem[12'h68C] = 16'd16;
    mem[12'h686] = 16'd99;
    run("cnt_max_top", mk(2, 16'h0100, 16'h0100, 9, 5, 3, 9, 2, 16'h000F), 1'b0);
    mem[12'h68C] = 16'd3;
    run("mode1_explore", mk(1, 16'h0100, 16'h00F0, 9, 5, 3, 16'd8, 2, 16'h0004), 1'b0);
    run("mode3_greedy", mk(3, 16'h0100, 16'h00F0, 9, 5, 3, 16'd4, 2, 16'h0004), 1'b0);
    run("busy_poke", mk(0, 16'h0100, 16'h0100, 11, 5, 3, 9, 2, 16'h0001), 1'b1);
    run("busy_poke_x", mk(2, 16'h0100, 16'h0100, 11, 5, 3, 9, 2, 16'h0007), 1'b1);

    // Randomized requests.
    for (int n = 0; n < 30; n++) begin
      k = int'($urandom_range(0, 5));
      mem[12'h68C] = (k == 0) ? 16'd0 : (k == 1) ? 16'd40 : 16'($urandom_range(1, 20));
      t.mode   = int'($urandom_range(0, 3));
      t.mybest = 16'($urandom_range(1, 16'h3000));
      k = int'($urandom_range(0, 2));
      t.bestvalue = (k == 0) ? 16'($urandom) : (k == 1) ? t.mybest
                  : 16'(t.mybest - 16'($urandom_range(0, 2)));
      t.besthop = 16'($urandom_range(0, 63));
      t.myid    = 16'($urandom_range(0, 7));
      t.bnid    = ($urandom_range(0, 1) == 0) ? t.myid : 16'($urandom_range(0, 7));
      t.eps     = 16'($urandom_range(0, 18));
      t.step    = 16'($urandom_range(0, 6));
      t.rnd     = 16'($urandom);
      run($sformatf("rand%0d", n), t, 1'(n % 4 == 0));
    end

    // Known explore result so the reset below has something to clear.
    mem[12'h68C] = 16'd5;
    mem[12'h66E] = 16'd42;
    run("pre_reset", mk(2, 16'h0100, 16'h0100, 7, 5, 3, 9, 2, 16'h000D), 1'b0);

    // Reset in the middle of a long modulo loop (count 1, slice 15).
    mem[12'h68C] = 16'd1;
    drive(mk(2, 16'h0100, 16'h0100, 7, 5, 3, 9, 2, 16'h000F));
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (5) begin
      @(posedge clock); #1;
    end
    check("mid_busy", 32'(busy), 32'd1);
    #2 nreset = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_nexthop", 32'(nexthop), 32'd100);
    check("arst_epsilon_next", 32'(epsilon_next), 32'd0);
    check("arst_explored", 32'(explored), 32'd0);
    check("arst_mem_addr", 32'(mem_addr), 32'd0);
    check("arst_mem_rd_en", 32'(mem_rd_en), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    $display("txn async_reset busy=%0d nexthop=%0d", busy, nexthop);
    @(negedge clock); @(negedge clock);
    nreset = 1'b1;
    @(negedge clock);
    check("post_reset_idle", 32'(busy), 32'd0);
    run("after_reset", mk(0, 16'h0100, 16'h00F0, 21, 1, 2, 9, 2, 16'h0003), 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
